cluster_ldst_split: RTL and testbench
=====================================

# cluster_ldst_split

Wide-to-narrow AXI splitter sitting between a system-side AXI manager (AxiDataWidth) and NrClusters Ara lane-group AXI subordinate ports (ClusterAxiDataWidth each). It forks every AW/AR to all clusters with rescaled size/address, slices each wide W beat into per-cluster beats, gathers per-cluster R beats into one wide beat, and joins the per-cluster B responses. Only full-bandwidth configurations are supported: NrClusters*ClusterAxiDataWidth == AxiDataWidth.

## Interface

- NrClusters, 4: number of lane-group ports; power of two, >= 2.
- AxiDataWidth, 256: system-side data width in bits.
- ClusterAxiDataWidth, 64: per-cluster data width; must equal AxiDataWidth/NrClusters (elaboration error otherwise).
- axi_req_t / axi_resp_t, logic: wide AXI request/response structs.
- cluster_axi_req_t / cluster_axi_resp_t, logic: narrow AXI request/response structs.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- axi_req_i  in  axi_req_t  wide requests from system side.
- axi_resp_o  out  axi_resp_t  wide responses to system side.
- cluster_axi_req_o  out  cluster_axi_req_t[NrClusters]  narrow requests to clusters.
- cluster_axi_resp_i  in  cluster_axi_resp_t[NrClusters]  narrow responses from clusters.

## Operation

- AW/AR fork: request forwarded to all clusters with len, id, burst, user unchanged; size = size - log2(NrClusters); addr = addr >> log2(NrClusters). Per-channel `sent[NrClusters]` register records clusters that already handshook; cluster i valid = upstream valid & ~sent[i]. Upstream ready = all clusters either sent or ready this cycle; sent clears on upstream handshake.
- Wide requests must have size == log2(AxiDataWidth/8) and aligned addr; other sizes are forwarded unchecked (undefined data mapping).
- W split: one-entry buffer per cluster holding data/strb slice i (bits i*ClusterAxiDataWidth +: ClusterAxiDataWidth), last, user. Upstream w_ready = every buffer empty or popping this cycle. Accepted wide beat loads all buffers simultaneously; each cluster drains independently.
- R gather: one-entry buffer per cluster. Cluster r_ready = own buffer empty or wide beat being consumed. Wide r_valid when all buffers full; data = concatenation (cluster 0 lowest); id/user from cluster 0; resp = maximum over clusters; last = AND of lasts. All buffers clear on wide handshake.
- B join: per-cluster one-entry B buffer; wide b_valid when all full; id from cluster 0, resp = maximum; all clear on wide handshake.
- Last mismatch (some but not all R lasts set) raises an assertion; hardware still uses AND.

## Timing

- Reset: all cluster *_valid and wide r_valid/b_valid 0; sent bits 0; all buffers empty; wide w_ready 1; aw_ready/ar_ready follow cluster readies combinationally.
- AW/AR: zero-latency combinational fork; no storage beyond sent bits.
- W: wide beat at cycle t → cluster w_valid at t+1. Full throughput (one beat/cycle) when all clusters hold w_ready high.
- R/B: wide valid one cycle after the last missing cluster beat is captured. Wide beat consumed at t while new cluster beats arrive at t: new beats captured at t, full throughput.
- Simultaneous AW and W: independent; W may precede AW.
- rst_i mid-burst: all buffers and sent bits clear next edge; in-flight beats dropped.

## Structure

- Shared package: none needed beyond existing Ara AXI typedefs; localparams SizeShift = log2(NrClusters), WideSize = log2(AxiDataWidth/8) local.
- Sub-module: `cluster_ldst_fork` (valid/ready fork with sent bits) instantiated for AW and AR.

## Test plan

- Reset: assert rst_i 2 cycles → all cluster valids 0, w_ready 1, r_valid 0, b_valid 0.
- AW addr 0x1000 size 5 len 3 with cluster 2 ready delayed 3 cycles → clusters get addr 0x400 size 3 len 3; cluster 2 sees exactly one handshake; upstream aw_ready only in cycle cluster 2 accepts.
- W beat data 0x{D3,D2,D1,D0} (64-bit slices), strb all ones, last=1 → cluster i receives Di, strb 0xFF, last 1 one cycle later; cluster 1 stalls 2 cycles → next wide beat held off until it drains.
- R beats arriving staggered (cluster 3 last, 4 cycles late) with resp OKAY except cluster 1 SLVERR → single wide beat, concatenated data, resp SLVERR, one cycle after cluster 3 capture.
- Back-to-back 8-beat read, all clusters always valid, upstream r_ready constant 1 → 8 wide beats in 8 consecutive cycles, last only on beat 8.
- rst_i asserted with 2 W beats buffered → buffers empty, no further cluster w_valid.

Source files
------------

// File: rtl/cluster_ldst_split_pkg.sv
// Shared configuration, AXI channel/bundle types and helpers for the
// wide-to-narrow cluster load/store splitter.
package cluster_ldst_split_pkg;

    localparam int unsigned CfgNrClusters          = 4;
    localparam int unsigned CfgAxiDataWidth        = 256;
    localparam int unsigned CfgClusterAxiDataWidth = CfgAxiDataWidth / CfgNrClusters;
    localparam int unsigned AddrWidth              = 32;
    localparam int unsigned IdWidth                = 4;
    localparam int unsigned UserWidth              = 2;

    typedef enum logic [1:0] {
        RespOkay   = 2'd0,
        RespExOkay = 2'd1,
        RespSlvErr = 2'd2,
        RespDecErr = 2'd3
    } axi_resp_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [CfgAxiDataWidth-1:0]   data;
        logic [CfgAxiDataWidth/8-1:0] strb;
        logic                         last;
        logic [UserWidth-1:0]         user;
    } wide_w_t;

    typedef struct packed {
        logic [CfgClusterAxiDataWidth-1:0]   data;
        logic [CfgClusterAxiDataWidth/8-1:0] strb;
        logic                                last;
        logic [UserWidth-1:0]                user;
    } narrow_w_t;

    typedef struct packed {
        logic [IdWidth-1:0]         id;
        logic [CfgAxiDataWidth-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
        logic [UserWidth-1:0]       user;
    } wide_r_t;

    typedef struct packed {
        logic [IdWidth-1:0]                id;
        logic [CfgClusterAxiDataWidth-1:0] data;
        logic [1:0]                        resp;
        logic                              last;
        logic [UserWidth-1:0]              user;
    } narrow_r_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        wide_w_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } wide_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        wide_r_t r;
        logic    r_valid;
    } wide_resp_t;

    typedef struct packed {
        ax_chan_t  aw;
        logic      aw_valid;
        narrow_w_t w;
        logic      w_valid;
        logic      b_ready;
        ax_chan_t  ar;
        logic      ar_valid;
        logic      r_ready;
    } narrow_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      ar_ready;
        logic      w_ready;
        b_chan_t   b;
        logic      b_valid;
        narrow_r_t r;
        logic      r_valid;
    } narrow_resp_t;

    // AXI response codes are ordered by severity, so the worst one is the largest.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cluster_ldst_fork.sv
// Valid/ready fork: one upstream handshake completes only once every
// downstream port has accepted; sent bits stop re-offering to early acceptors.
module cluster_ldst_fork #(
    parameter int unsigned NrPorts = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [NrPorts-1:0] valid_o,
    input  logic [NrPorts-1:0] ready_i
);

    logic [NrPorts-1:0] sent_q, sent_d;

    always_comb begin
        valid_o = {NrPorts{valid_i}} & ~sent_q;
        ready_o = &(sent_q | ready_i);
        sent_d  = sent_q | (valid_o & ready_i);
        if (valid_i && ready_o) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/cluster_ldst_split.sv
// Splits one wide AXI port into NrClusters narrow lane-group ports:
// AW/AR fork, W slicing, R gathering and B joining.
module cluster_ldst_split
    import cluster_ldst_split_pkg::*;
#(
    parameter int unsigned NrClusters          = CfgNrClusters,
    parameter int unsigned AxiDataWidth        = CfgAxiDataWidth,
    parameter int unsigned ClusterAxiDataWidth = CfgClusterAxiDataWidth,
    parameter type axi_req_t                   = wide_req_t,
    parameter type axi_resp_t                  = wide_resp_t,
    parameter type cluster_axi_req_t           = narrow_req_t,
    parameter type cluster_axi_resp_t          = narrow_resp_t
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  axi_req_t          axi_req_i,
    output axi_resp_t         axi_resp_o,
    output cluster_axi_req_t  cluster_axi_req_o [NrClusters],
    input  cluster_axi_resp_t cluster_axi_resp_i [NrClusters]
);

    localparam int unsigned SizeShift = $clog2(NrClusters);
    localparam int unsigned WideSize  = $clog2(AxiDataWidth / 8);
    localparam int unsigned CStrb     = ClusterAxiDataWidth / 8;

    if (NrClusters * ClusterAxiDataWidth != AxiDataWidth) begin : g_bad_width
        $error("cluster_ldst_split: NrClusters*ClusterAxiDataWidth must equal AxiDataWidth");
    end
    if (NrClusters < 2 || (1 << SizeShift) != NrClusters) begin : g_bad_count
        $error("cluster_ldst_split: NrClusters must be a power of two >= 2");
    end
    if (WideSize != $clog2(CStrb) + SizeShift) begin : g_bad_size
        $error("cluster_ldst_split: narrow beat size does not rescale from the wide size");
    end

    logic [NrClusters-1:0] aw_valid, aw_ready, ar_valid, ar_ready;
    logic [NrClusters-1:0] c_w_ready, c_r_valid, c_r_ready, c_b_valid, c_b_ready;
    logic [NrClusters-1:0] w_pop, r_last;
    logic [NrClusters-1:0] w_full_q, w_full_d, r_full_q, r_full_d, b_full_q, b_full_d;
    logic                  aw_ready_up, ar_ready_up, w_ready_up;
    logic                  r_valid_up, r_hs, b_valid_up, b_hs;
    logic                  unused_bits;
    narrow_w_t             w_buf_q [NrClusters];
    narrow_w_t             w_buf_d [NrClusters];
    narrow_r_t             r_buf_q [NrClusters];
    narrow_r_t             r_buf_d [NrClusters];
    b_chan_t               b_buf_q [NrClusters];
    b_chan_t               b_buf_d [NrClusters];

    cluster_ldst_fork #(.NrPorts(NrClusters)) i_aw_fork (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (axi_req_i.aw_valid),
        .ready_o (aw_ready_up),
        .valid_o (aw_valid),
        .ready_i (aw_ready)
    );

    cluster_ldst_fork #(.NrPorts(NrClusters)) i_ar_fork (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (axi_req_i.ar_valid),
        .ready_o (ar_ready_up),
        .valid_o (ar_valid),
        .ready_i (ar_ready)
    );

    always_comb begin
        aw_ready  = '0;
        ar_ready  = '0;
        c_w_ready = '0;
        c_r_valid = '0;
        c_b_valid = '0;
        for (int i = 0; i < NrClusters; i++) begin
            aw_ready[i]  = cluster_axi_resp_i[i].aw_ready;
            ar_ready[i]  = cluster_axi_resp_i[i].ar_ready;
            c_w_ready[i] = cluster_axi_resp_i[i].w_ready;
            c_r_valid[i] = cluster_axi_resp_i[i].r_valid;
            c_b_valid[i] = cluster_axi_resp_i[i].b_valid;
        end
    end

    // A wide W beat is accepted only when every slice buffer can take its part.
    always_comb begin
        w_pop      = w_full_q & c_w_ready;
        w_ready_up = &(~w_full_q | w_pop);
        w_full_d   = w_full_q & ~w_pop;
        w_buf_d    = w_buf_q;
        if (axi_req_i.w_valid && w_ready_up) begin
            w_full_d = '1;
            for (int i = 0; i < NrClusters; i++) begin
                w_buf_d[i].data = axi_req_i.w.data[i*ClusterAxiDataWidth +: ClusterAxiDataWidth];
                w_buf_d[i].strb = axi_req_i.w.strb[i*CStrb +: CStrb];
                w_buf_d[i].last = axi_req_i.w.last;
                w_buf_d[i].user = axi_req_i.w.user;
            end
        end
    end

    always_comb begin
        r_valid_up = &r_full_q;
        r_hs       = r_valid_up & axi_req_i.r_ready;
        c_r_ready  = ~r_full_q | {NrClusters{r_hs}};
        r_full_d   = r_hs ? '0 : r_full_q;
        r_buf_d    = r_buf_q;
        b_valid_up = &b_full_q;
        b_hs       = b_valid_up & axi_req_i.b_ready;
        c_b_ready  = ~b_full_q | {NrClusters{b_hs}};
        b_full_d   = b_hs ? '0 : b_full_q;
        b_buf_d    = b_buf_q;
        for (int i = 0; i < NrClusters; i++) begin
            if (c_r_valid[i] && c_r_ready[i]) begin
                r_full_d[i] = 1'b1;
                r_buf_d[i]  = cluster_axi_resp_i[i].r;
            end
            if (c_b_valid[i] && c_b_ready[i]) begin
                b_full_d[i] = 1'b1;
                b_buf_d[i]  = cluster_axi_resp_i[i].b;
            end
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_up;
        axi_resp_o.ar_ready = ar_ready_up;
        axi_resp_o.w_ready  = w_ready_up;
        axi_resp_o.r_valid  = r_valid_up;
        axi_resp_o.r.id     = r_buf_q[0].id;
        axi_resp_o.r.user   = r_buf_q[0].user;
        axi_resp_o.r.resp   = RespOkay;
        axi_resp_o.b_valid  = b_valid_up;
        axi_resp_o.b.id     = b_buf_q[0].id;
        axi_resp_o.b.user   = b_buf_q[0].user;
        axi_resp_o.b.resp   = RespOkay;
        r_last              = '0;
        unused_bits         = 1'b0;
        for (int i = 0; i < NrClusters; i++) begin
            r_last[i] = r_buf_q[i].last;
            axi_resp_o.r.data[i*ClusterAxiDataWidth +: ClusterAxiDataWidth] = r_buf_q[i].data;
            axi_resp_o.r.resp = resp_max(axi_resp_o.r.resp, r_buf_q[i].resp);
            axi_resp_o.b.resp = resp_max(axi_resp_o.b.resp, b_buf_q[i].resp);
            unused_bits = unused_bits ^ (^{r_buf_q[i].id, r_buf_q[i].user,
                                           b_buf_q[i].id, b_buf_q[i].user});

            cluster_axi_req_o[i]          = '0;
            cluster_axi_req_o[i].aw       = axi_req_i.aw;
            cluster_axi_req_o[i].aw.size  = axi_req_i.aw.size - 3'(SizeShift);
            cluster_axi_req_o[i].aw.addr  = axi_req_i.aw.addr >> SizeShift;
            cluster_axi_req_o[i].aw_valid = aw_valid[i];
            cluster_axi_req_o[i].ar       = axi_req_i.ar;
            cluster_axi_req_o[i].ar.size  = axi_req_i.ar.size - 3'(SizeShift);
            cluster_axi_req_o[i].ar.addr  = axi_req_i.ar.addr >> SizeShift;
            cluster_axi_req_o[i].ar_valid = ar_valid[i];
            cluster_axi_req_o[i].w        = w_buf_q[i];
            cluster_axi_req_o[i].w_valid  = w_full_q[i];
            cluster_axi_req_o[i].r_ready  = c_r_ready[i];
            cluster_axi_req_o[i].b_ready  = c_b_ready[i];
        end
        axi_resp_o.r.last = &r_last;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_full_q <= '0;
            r_full_q <= '0;
            b_full_q <= '0;
        end else begin
            w_full_q <= w_full_d;
            r_full_q <= r_full_d;
            b_full_q <= b_full_d;
        end
    end

    // Payload registers need no reset; the full bits qualify them.
    always_ff @(posedge clk_i) begin
        w_buf_q <= w_buf_d;
        r_buf_q <= r_buf_d;
        b_buf_q <= b_buf_d;
    end

    // Clusters disagreeing on RLAST means the burst lengths diverged.
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_valid_up) begin
            assert (&r_last || ~|r_last);
        end
    end

endmodule

// File: tb/tb_cluster_ldst_split.sv
// Directed self-checking bench for cluster_ldst_split: reset, AW fork with a
// late cluster, W split with a stalled cluster, R gather, B join, reset flush.
module tb_cluster_ldst_split;
    import cluster_ldst_split_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    wide_req_t    req;
    wide_resp_t   resp;
    narrow_req_t  creq  [CfgNrClusters];
    narrow_resp_t cresp [CfgNrClusters];
    int           checks = 0;
    int           errors = 0;
    int           aw2_hs = 0;
    logic [255:0] exp_data;

    always #5 clk = ~clk;

    cluster_ldst_split dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .axi_req_i          (req),
        .axi_resp_o         (resp),
        .cluster_axi_req_o  (creq),
        .cluster_axi_resp_i (cresp)
    );

    // Counts AW handshakes seen by cluster 2 to prove it is offered the request only once.
    always @(posedge clk) begin
        if (!rst_i && creq[2].aw_valid && cresp[2].aw_ready) aw2_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gathers one per-cluster handshake signal into a vector: 0 aw_valid, 1 w_valid, 2 r_ready, 3 b_ready.
    function automatic logic [3:0] cvec(input int ch);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            case (ch)
                0:       v[i] = creq[i].aw_valid;
                1:       v[i] = creq[i].w_valid;
                2:       v[i] = creq[i].r_ready;
                default: v[i] = creq[i].b_ready;
            endcase
        end
        return v;
    endfunction

    function automatic logic [63:0] dval(input int i);
        return {32'hD0D0_D0D0, 32'(i)};
    endfunction

    function automatic logic [63:0] eval(input int i);
        return {32'hE0E0_E0E0, 32'(i)};
    endfunction

    function automatic logic [63:0] fval(input int i);
        return {32'hF0F0_F0F0, 32'(i)};
    endfunction

    function automatic logic [63:0] bval(input int k, input int i);
        return {32'hBEEF_0000 + 32'(k), 32'(i)};
    endfunction

    task automatic applyStimulus();
        req   = '0;
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) cresp[i] = '0;

        // Reset held for two cycles
        tick();
        tick();
        settle();
        checkOutput("rst_aw_w_valids", {cvec(0), cvec(1)}, 8'h00);
        checkOutput("rst_w_ready", resp.w_ready, 1'b1);
        checkOutput("rst_r_valid", resp.r_valid, 1'b0);
        checkOutput("rst_b_valid", resp.b_valid, 1'b0);
        checkOutput("rst_aw_ready_low", resp.aw_ready, 1'b0);
        for (int i = 0; i < 4; i++) cresp[i].aw_ready = 1'b1;
        settle();
        checkOutput("rst_aw_ready_high", resp.aw_ready, 1'b1);
        rst_i = 1'b0;

        // AW fork with cluster 2 accepting three cycles late
        tick();
        cresp[2].aw_ready = 1'b0;
        req.aw.id    = 4'd5;
        req.aw.addr  = 32'h1000;
        req.aw.len   = 8'd3;
        req.aw.size  = 3'd5;
        req.aw.burst = 2'd1;
        req.aw_valid = 1'b1;
        settle();
        checkOutput("aw_addr", creq[2].aw.addr, 32'h400);
        checkOutput("aw_size", creq[3].aw.size, 3'd3);
        checkOutput("aw_len", creq[1].aw.len, 8'd3);
        checkOutput("aw_id", creq[0].aw.id, 4'd5);
        checkOutput("aw_valid_c0", cvec(0), 4'hF);
        checkOutput("aw_ready_c0", resp.aw_ready, 1'b0);
        tick();
        settle();
        checkOutput("aw_valid_c1", cvec(0), 4'b0100);
        checkOutput("aw_ready_c1", resp.aw_ready, 1'b0);
        tick();
        settle();
        checkOutput("aw_ready_c2", resp.aw_ready, 1'b0);
        tick();
        cresp[2].aw_ready = 1'b1;
        settle();
        checkOutput("aw_valid_c3", cvec(0), 4'b0100);
        checkOutput("aw_ready_c3", resp.aw_ready, 1'b1);
        tick();
        settle();
        checkOutput("aw_c2_handshakes", aw2_hs, 1);
        checkOutput("aw_sent_cleared", cvec(0), 4'hF);
        checkOutput("aw_ready_next", resp.aw_ready, 1'b1);
        tick();
        req.aw_valid = 1'b0;
        settle();
        checkOutput("aw_idle", cvec(0), 4'h0);

        // W split, then cluster 1 stalls for two cycles
        for (int i = 0; i < 4; i++) cresp[i].w_ready = 1'b1;
        for (int i = 0; i < 4; i++) req.w.data[i*64 +: 64] = dval(i);
        req.w.strb  = '1;
        req.w.last  = 1'b1;
        req.w_valid = 1'b1;
        settle();
        checkOutput("w_ready_empty", resp.w_ready, 1'b1);
        checkOutput("w_valid_before", cvec(1), 4'h0);
        tick();
        for (int i = 0; i < 4; i++) req.w.data[i*64 +: 64] = eval(i);
        req.w.last        = 1'b0;
        cresp[1].w_ready  = 1'b0;
        settle();
        checkOutput("w_valid_split", cvec(1), 4'hF);
        checkOutput("w_data_c0", creq[0].w.data, dval(0));
        checkOutput("w_data_c1", creq[1].w.data, dval(1));
        checkOutput("w_data_c3", creq[3].w.data, dval(3));
        checkOutput("w_strb_c2", creq[2].w.strb, 8'hFF);
        checkOutput("w_last_c2", creq[2].w.last, 1'b1);
        checkOutput("w_ready_stall1", resp.w_ready, 1'b0);
        tick();
        settle();
        checkOutput("w_valid_stalled", cvec(1), 4'b0010);
        checkOutput("w_ready_stall2", resp.w_ready, 1'b0);
        tick();
        cresp[1].w_ready = 1'b1;
        settle();
        checkOutput("w_ready_drain", resp.w_ready, 1'b1);
        tick();
        req.w_valid = 1'b0;
        settle();
        checkOutput("w_valid_second", cvec(1), 4'hF);
        checkOutput("w_data2_c1", creq[1].w.data, eval(1));
        checkOutput("w_last2_c2", creq[2].w.last, 1'b0);

        // Reset while beats are buffered and an AW is half-forked
        for (int i = 0; i < 4; i++) cresp[i].w_ready = 1'b0;
        cresp[0].aw_ready = 1'b0;
        req.aw_valid      = 1'b1;
        tick();
        settle();
        checkOutput("flush_w_held", cvec(1), 4'hF);
        checkOutput("flush_w_ready", resp.w_ready, 1'b0);
        checkOutput("flush_aw_partial", cvec(0), 4'b0001);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        checkOutput("flush_w_valid", cvec(1), 4'h0);
        checkOutput("flush_w_ready_up", resp.w_ready, 1'b1);
        checkOutput("flush_aw_sent", cvec(0), 4'hF);
        req.aw_valid      = 1'b0;
        cresp[0].aw_ready = 1'b1;
        tick();
        settle();
        checkOutput("flush_w_quiet", cvec(1), 4'h0);

        // R gather with cluster 3 four cycles late and cluster 1 SLVERR
        req.r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cresp[i].r.id   = (i == 0) ? 4'd7 : 4'd0;
            cresp[i].r.data = fval(i);
            cresp[i].r.resp = (i == 1) ? RespSlvErr : RespOkay;
            cresp[i].r.last = 1'b1;
            cresp[i].r_valid = (i != 3);
        end
        settle();
        checkOutput("r_ready_empty", cvec(2), 4'hF);
        tick();
        for (int i = 0; i < 3; i++) cresp[i].r_valid = 1'b0;
        settle();
        checkOutput("r_valid_partial", resp.r_valid, 1'b0);
        checkOutput("r_ready_partial", cvec(2), 4'b1000);
        tick();
        tick();
        tick();
        cresp[3].r_valid = 1'b1;
        settle();
        checkOutput("r_valid_wait", resp.r_valid, 1'b0);
        tick();
        cresp[3].r_valid = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) exp_data[i*64 +: 64] = fval(i);
        checkOutput("r_valid_gather", resp.r_valid, 1'b1);
        checkOutput("r_data_gather", resp.r.data, exp_data);
        checkOutput("r_resp_gather", resp.r.resp, RespSlvErr);
        checkOutput("r_last_gather", resp.r.last, 1'b1);
        checkOutput("r_id_gather", resp.r.id, 4'd7);
        tick();
        settle();
        checkOutput("r_valid_consumed", resp.r_valid, 1'b0);
        checkOutput("r_ready_consumed", cvec(2), 4'hF);

        // B join with upstream back-pressure
        req.b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cresp[i].b.id    = (i == 0) ? 4'd9 : 4'd0;
            cresp[i].b.resp  = (i == 2) ? RespExOkay : RespOkay;
            cresp[i].b_valid = (i != 1);
        end
        tick();
        for (int i = 0; i < 4; i++) cresp[i].b_valid = 1'b0;
        settle();
        checkOutput("b_valid_partial", resp.b_valid, 1'b0);
        checkOutput("b_ready_partial", cvec(3), 4'b0010);
        cresp[1].b.resp  = RespDecErr;
        cresp[1].b_valid = 1'b1;
        tick();
        cresp[1].b_valid = 1'b0;
        settle();
        checkOutput("b_valid_join", resp.b_valid, 1'b1);
        checkOutput("b_resp_join", resp.b.resp, RespDecErr);
        checkOutput("b_id_join", resp.b.id, 4'd9);
        checkOutput("b_ready_full", cvec(3), 4'h0);
        tick();
        settle();
        checkOutput("b_valid_held", resp.b_valid, 1'b1);
        req.b_ready = 1'b1;
        settle();
        checkOutput("b_ready_on_hs", cvec(3), 4'hF);
        tick();
        settle();
        checkOutput("b_valid_consumed", resp.b_valid, 1'b0);
        req.b_ready = 1'b0;

        // Back-to-back 8-beat read at full throughput
        for (int k = 0; k <= 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                cresp[i].r.id    = 4'd0;
                cresp[i].r.data  = bval(k, i);
                cresp[i].r.resp  = RespOkay;
                cresp[i].r.last  = (k == 7);
                cresp[i].r_valid = (k < 8);
            end
            settle();
            if (k >= 1) begin
                for (int i = 0; i < 4; i++) exp_data[i*64 +: 64] = bval(k - 1, i);
                checkOutput($sformatf("burst_valid_%0d", k - 1), resp.r_valid, 1'b1);
                checkOutput($sformatf("burst_data_%0d", k - 1), resp.r.data, exp_data);
                checkOutput($sformatf("burst_last_%0d", k - 1), resp.r.last, (k - 1 == 7));
            end
            tick();
        end
        settle();
        checkOutput("burst_done", resp.r_valid, 1'b0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
